// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryption controller: alternates key-expansion and round phases
// through one shared, external combinational SubBytes instance.
module aes128_enc_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext,
    output logic [127:0] sbox_in,
    input  logic [127:0] sbox_out
);

    localparam logic [3:0] LastRound = 4'(NR);

    typedef enum logic [1:0] {StIdle, StKey, StData, StDone} fsm_e;

    fsm_e         fsm_q;
    logic [3:0]   round_q;
    logic [127:0] data_q;
    logic [127:0] rk_q;

    logic [31:0]  sub_word;
    logic [31:0]  w0_d, w1_d, w2_d, w3_d;
    logic [127:0] sr_out;
    logic [127:0] mc_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte 4c+r is row r of column c; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            res[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return res;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    always_comb begin
        sub_word = sbox_out[31:0] ^ {rcon(round_q), 24'h0};
        w0_d     = rk_q[127:96] ^ sub_word;
        w1_d     = rk_q[95:64] ^ w0_d;
        w2_d     = rk_q[63:32] ^ w1_d;
        w3_d     = rk_q[31:0] ^ w2_d;
        sr_out   = shift_rows(sbox_out);
        mc_out   = mix_columns(sr_out);
    end

    // The S-box operand is parked at zero outside the active phases.
    always_comb begin
        sbox_in = '0;
        unique case (fsm_q)
            StKey:   sbox_in = {96'h0, rk_q[23:0], rk_q[31:24]};
            StData:  sbox_in = data_q;
            default: sbox_in = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= StIdle;
            round_q    <= '0;
            data_q     <= '0;
            rk_q       <= '0;
            ciphertext <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (fsm_q)
                StIdle, StDone: begin
                    if (start) begin
                        data_q  <= plaintext ^ key;
                        rk_q    <= key;
                        round_q <= 4'd1;
                        busy    <= 1'b1;
                        fsm_q   <= StKey;
                    end
                end
                StKey: begin
                    rk_q  <= {w0_d, w1_d, w2_d, w3_d};
                    fsm_q <= StData;
                end
                StData: begin
                    if (round_q == LastRound) begin
                        ciphertext <= sr_out ^ rk_q;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        fsm_q      <= StDone;
                    end else begin
                        data_q  <= mc_out ^ rk_q;
                        round_q <= round_q + 4'd1;
                        fsm_q   <= StKey;
                    end
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// Directed bench for aes128_enc_ctrl using FIPS-197 vectors and a table-driven SubBytes model.
module tb_aes128_enc_ctrl;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;
    logic [127:0] sbox_in;
    logic [127:0] sbox_out;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] sbox_tab [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    aes128_enc_ctrl #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext),
        .sbox_in    (sbox_in),
        .sbox_out   (sbox_out)
    );

    always #5 clk = ~clk;

    always_comb begin
        sbox_out = '0;
        for (int i = 0; i < 16; i++) begin
            sbox_out[8*i +: 8] = sbox_tab[sbox_in[8*i +: 8]];
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accepting edge E0.
    task automatic launch(input logic [127:0] p, input logic [127:0] k);
        start     = 1'b1;
        plaintext = p;
        key       = k;
        step();
        start = 1'b0;
    endtask

    // Cycle i is sampled just after edge E(i) following the accepting edge.
    task automatic run(input logic disturb, input int ncyc, input logic stop_at_done,
                       output int first_done, output int n_done, output int n_busy,
                       output logic [127:0] ct_at_done);
        first_done = 0;
        n_done     = 0;
        n_busy     = 0;
        ct_at_done = '0;
        for (int i = 1; i <= ncyc; i++) begin
            step();
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = i;
                    ct_at_done = ciphertext;
                end
                if (stop_at_done) break;
            end
            if (disturb) begin
                if (i == 5 || i == 12) begin
                    start     = 1'b1;
                    plaintext = {$urandom, $urandom, $urandom, $urandom};
                    key       = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    start = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          fd, nd, nb;
        logic [127:0] ct;

        rst       = 1'b1;
        start     = 1'b0;
        plaintext = '0;
        key       = '0;
        step();
        step();
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_ct", ciphertext, 128'h0);
        check("reset_sbox_in", sbox_in, 128'h0);
        rst = 1'b0;
        step();

        // FIPS-197 C.1
        launch(PT_C1, K_C1);
        check("c1_busy_e0", 128'(busy), 128'(1));
        run(1'b0, 40, 1'b1, fd, nd, nb, ct);
        check("c1_latency", 128'(fd), 128'(20));
        check("c1_busy_cycles", 128'(nb + 1), 128'(20));
        check("c1_ct", ct, CT_C1);
        check("c1_busy_in_done", 128'(busy), 128'(0));
        step();
        check("c1_done_pulse", 128'(done), 128'(0));

        // FIPS-197 App. B, including the first SubWord operand
        launch(PT_B, K_B);
        check("b_sbox_key", sbox_in, {96'h0, 32'hcf4f3c09});
        run(1'b0, 40, 1'b1, fd, nd, nb, ct);
        check("b_latency", 128'(fd), 128'(20));
        check("b_ct", ct, CT_B);
        step();

        // Back-to-back: second start issued in the done cycle
        launch(PT_C1, K_C1);
        run(1'b0, 40, 1'b1, fd, nd, nb, ct);
        check("b2b_first_latency", 128'(fd), 128'(20));
        check("b2b_first_ct", ct, CT_C1);
        start     = 1'b1;
        plaintext = PT_B;
        key       = K_B;
        check("b2b_ct_hold", ciphertext, CT_C1);
        step();
        start = 1'b0;
        check("b2b_busy_again", 128'(busy), 128'(1));
        run(1'b0, 40, 1'b1, fd, nd, nb, ct);
        check("b2b_second_gap", 128'(fd + 1), 128'(21));
        check("b2b_second_ct", ct, CT_B);
        step();

        // start and input changes while busy are ignored
        launch(PT_C1, K_C1);
        run(1'b1, 30, 1'b0, fd, nd, nb, ct);
        check("ign_latency", 128'(fd), 128'(20));
        check("ign_done_count", 128'(nd), 128'(1));
        check("ign_ct", ct, CT_C1);
        check("ign_ct_final", ciphertext, CT_C1);

        // Asynchronous reset in the round-6 key phase
        launch(PT_C1, K_C1);
        for (int i = 0; i < 10; i++) step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_done", 128'(done), 128'(0));
        check("arst_ct", ciphertext, 128'h0);
        check("arst_sbox_in", sbox_in, 128'h0);
        step();
        rst = 1'b0;
        run(1'b0, 30, 1'b0, fd, nd, nb, ct);
        check("arst_no_done", 128'(nd), 128'(0));
        check("arst_no_busy", 128'(nb), 128'(0));
        launch(PT_C1, K_C1);
        run(1'b0, 40, 1'b1, fd, nd, nb, ct);
        check("arst_rerun_latency", 128'(fd), 128'(20));
        check("arst_rerun_ct", ct, CT_C1);
        step();

        // Idle without start
        for (int i = 0; i < 50; i++) begin
            step();
            check("idle_sbox_in", sbox_in, 128'h0);
            check("idle_done", 128'(done), 128'(0));
            check("idle_busy", 128'(busy), 128'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
